uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 16, clk cycles per UART bit (even, >=4).
REQ-002 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rx_in  in  1  asynchronous serial line, idle high.
REQ-006 sipo_shift  out  1  one-cycle strobe: SIPO captures sipo_bit.
REQ-007 sipo_bit  out  1  sampled line value presented with sipo_shift.
REQ-008 sipo_frame  in  11  SIPO parallel word: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-009 rx_data  out  8  received byte.
REQ-010 rx_valid  out  1  rx_data, parity_err and frame_err valid.
REQ-011 rx_ready  in  1  consumer accepts when rx_valid && rx_ready.
REQ-012 parity_err  out  1  parity mismatch for the held byte.
REQ-013 frame_err  out  1  stop bit sampled 0 for the held byte.
REQ-014 overrun_err  out  1  one-cycle pulse: frame lost because rx_valid was still high.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 rx_in passes through a 2-FF synchronizer, reset value 1; all decisions use the synchronized value rx_s.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP, CHECK.
REQ-018 IDLE: a 1->0 transition on rx_s moves to START and clears the bit counter cnt.
REQ-019 START: at cnt == CLK_DIV/2-1, rx_s==0 -> pulse sipo_shift with sipo_bit=0, clear cnt, enter DATA; rx_s==1 -> IDLE (glitch), no shift.
REQ-020 DATA/PARITY/STOP: sample rx_s at cnt == CLK_DIV-1, pulse sipo_shift with sipo_bit=rx_s, clear cnt.
REQ-021 DATA takes exactly 8 samples (3-bit index), then PARITY takes 1 sample, then STOP takes 1 sample.
REQ-022 Exactly 11 sipo_shift pulses per accepted start; consecutive pulses spaced CLK_DIV cycles (first-to-second CLK_DIV cycles).
REQ-023 STOP sample -> CHECK the next cycle; CHECK reads sipo_frame and returns to IDLE in one cycle.
REQ-024 CHECK: computed parity = XOR(sipo_frame[9:1]) XOR PARITY_ODD; nonzero -> parity error.
REQ-025 CHECK: sipo_frame[10]==0 -> frame error; the FSM still returns to IDLE (no break handling).
REQ-026 CHECK with rx_valid==0 (or rx_valid && rx_ready in the same cycle): load rx_data=sipo_frame[8:1], parity_err, frame_err; set rx_valid the next cycle.
REQ-027 CHECK with rx_valid==1 and rx_ready==0: pulse overrun_err; hold rx_data, parity_err and frame_err unchanged.
REQ-028 rx_valid clears the cycle after rx_valid && rx_ready, unless reloaded in that cycle per REQ-026.
REQ-029 rx_valid, rx_data, parity_err and frame_err change only per REQ-026/028; they are stable while rx_valid && !rx_ready.
REQ-030 cnt width = $clog2(CLK_DIV); cnt does not wrap inside a bit period.

Reset
REQ-031 rst: state IDLE; cnt and bit index 0; synchronizer FFs 1.
REQ-032 rst: sipo_shift, sipo_bit, rx_data, rx_valid, parity_err, frame_err, overrun_err and busy are all 0.
REQ-033 rst mid-frame aborts the frame, emits no further sipo_shift, and discards any pending rx_valid.
REQ-034 After rst deasserts, the next start edge is received normally.

Structure
REQ-035 Package uart_pkg holds the FSM state enum, FRAME_W=11, DATA_W=8 and the frame bit-index constants.
REQ-036 The synchronizer is sub-module uart_sync2 (2 FFs, reset value parameterized); all other logic is flat.

Verification (CLK_DIV=16, PARITY_ODD=0; bench includes an 11-bit right-shifting SIPO model)
REQ-037 0xA5, parity 0, stop 1, rx_ready=1 -> 11 shifts at 16-cycle spacing; rx_valid with rx_data=0xA5; both error flags 0.
REQ-038 0x01 sent with parity bit 0 -> rx_valid with rx_data=0x01, parity_err=1, frame_err=0.
REQ-039 0x3C, parity 0, stop bit 0 -> frame_err=1, parity_err=0; next frame received clean.
REQ-040 rx_in low for 4 cycles then high -> no sipo_shift; back to IDLE; busy deasserts.
REQ-041 0x11 then 0x22 back-to-back with rx_ready=0 -> one overrun_err pulse; rx_data stays 0x11.
REQ-042 rst asserted during DATA bit 4 -> all outputs 0 next cycle; subsequent 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

    localparam int FRAME_W = 11;
    localparam int DATA_W  = 8;

    localparam int BIT_START    = 0;
    localparam int BIT_DATA_LSB = 1;
    localparam int BIT_DATA_MSB = 8;
    localparam int BIT_PARITY   = 9;
    localparam int BIT_STOP     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CHECK
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: times bit samples, strobes an external SIPO and
// checks the assembled frame for parity and stop-bit errors.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    output logic               sipo_shift,
    output logic               sipo_bit,
    input  logic [FRAME_W-1:0] sipo_frame,
    output logic [DATA_W-1:0]  rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               parity_err,
    output logic               frame_err,
    output logic               overrun_err,
    output logic               busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLK_DIV / 2 - 1);

    logic              rx_s;
    uart_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        idx_q;
    logic              stop_done_q;
    logic              rx_prev_q;
    logic              shift_q;
    logic              bit_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              ovr_q;
    logic              busy_q;

    logic parity_err_d;
    logic frame_err_d;
    logic unused_start_bit;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_in),
        .q_o (rx_s)
    );

    assign parity_err_d     = (^sipo_frame[BIT_PARITY:BIT_DATA_LSB]) ^ PARITY_ODD;
    assign frame_err_d      = ~sipo_frame[BIT_STOP];
    assign unused_start_bit = sipo_frame[BIT_START];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_done_q <= 1'b0;
            rx_prev_q   <= 1'b1;
            shift_q     <= 1'b0;
            bit_q       <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            shift_q   <= 1'b0;
            ovr_q     <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            shift_q <= 1'b1;
                            bit_q   <= 1'b0;
                            idx_q   <= '0;
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= 1'b1;
                        bit_q   <= rx_s;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        shift_q     <= 1'b1;
                        bit_q       <= rx_s;
                        stop_done_q <= 1'b0;
                        state_q     <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Linger one cycle after the stop strobe so the SIPO has
                    // captured the stop bit before CHECK reads the frame.
                    if (stop_done_q) begin
                        stop_done_q <= 1'b0;
                        state_q     <= ST_CHECK;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        shift_q     <= 1'b1;
                        bit_q       <= rx_s;
                        stop_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!valid_q || rx_ready) begin
                        data_q  <= sipo_frame[BIT_DATA_MSB:BIT_DATA_LSB];
                        perr_q  <= parity_err_d;
                        ferr_q  <= frame_err_d;
                        valid_q <= 1'b1;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sipo_shift  = shift_q;
    assign sipo_bit    = bit_q;
    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with an external 11-bit SIPO model.
module tb_uart_rx_ctrl;

    localparam int BIT_T   = 16;
    localparam bit PAR_ODD = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_in;
    logic        rx_ready;
    logic        sipo_shift;
    logic        sipo_bit;
    logic [10:0] sipo_q;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int shift_stamps[$];
    logic [9:0] rx_q[$];

    uart_rx_ctrl #(.CLK_DIV(BIT_T), .PARITY_ODD(PAR_ODD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .sipo_shift  (sipo_shift),
        .sipo_bit    (sipo_bit),
        .sipo_frame  (sipo_q),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Right-shifting SIPO: first bit received ends up in [0].
    always @(posedge clk or posedge rst) begin
        if (rst) sipo_q <= '0;
        else if (sipo_shift) sipo_q <= {sipo_bit, sipo_q[10:1]};
    end

    always @(negedge clk) begin
        if (sipo_shift) shift_stamps.push_back(cyc);
        if (overrun_err) ovr_cnt <= ovr_cnt + 1;
        if (rx_valid && rx_ready) rx_q.push_back({parity_err, frame_err, rx_data});
    end

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected {parity_err, frame_err, data} for a frame as sent on the line.
    function automatic logic [9:0] model_rx(input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = $countones(d) + (p ? 1 : 0);
        return {((ones % 2) != int'(PAR_ODD)), ~s, d};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return (($countones(d) + int'(PAR_ODD)) % 2) != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_in = f[i];
            repeat (BIT_T) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({sipo_shift, sipo_bit, rx_valid, parity_err, frame_err, overrun_err, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {sipo_shift, sipo_bit, rx_valid, parity_err, frame_err, overrun_err, busy});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h expected 00", rx_data);
        end
        step();
        rst = 1'b0;
        repeat (5) step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++;
        if (shift_stamps.size() != 0) begin
            errors++; $display("FAIL reset_shift: got %0d expected 0", shift_stamps.size());
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        int bad;
        idle(5);
        rx_ready = 1'b1;
        rx_q.delete(); shift_stamps.delete();
        exp = model_rx(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (shift_stamps.size() != 11) begin
            errors++; $display("FAIL basic_shifts: got %0d expected 11", shift_stamps.size());
        end
        bad = 0;
        for (int i = 1; i < shift_stamps.size(); i++)
            if (shift_stamps[i] - shift_stamps[i-1] != BIT_T) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_spacing: got %0d bad gaps expected 0", bad); end
        checks++;
        if (sipo_q !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL basic_sipo: got %h expected %h", sipo_q, {1'b1, 1'b0, 8'hA5, 1'b0});
        end
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== exp) begin errors++; $display("FAIL basic_entry: got %h expected %h", rx_q[0], exp); end
        end
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_idle: got %b expected 00", {rx_valid, busy});
        end
    endtask

    task automatic test_parity_err();
        logic [9:0] exp;
        idle(5);
        rx_ready = 1'b1;
        rx_q.delete();
        exp = model_rx(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL parity_count: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== exp) begin errors++; $display("FAIL parity_entry: got %h expected %h", rx_q[0], exp); end
        end
    endtask

    task automatic test_frame_err();
        logic [9:0] exp;
        logic [7:0] d;
        logic       p;
        idle(5);
        rx_ready = 1'b1;
        rx_q.delete();
        exp = model_rx(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL frame_count: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== exp) begin errors++; $display("FAIL frame_entry: got %h expected %h", rx_q[0], exp); end
        end
        step();
        rx_q.delete();
        d = 8'($urandom_range(0, 255));
        p = good_par(d);
        exp = model_rx(d, p, 1'b1);
        send_frame(d, p, 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL frame_next_count: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== exp) begin errors++; $display("FAIL frame_next_entry: got %h expected %h", rx_q[0], exp); end
        end
    endtask

    task automatic test_glitch();
        logic seen;
        idle(5);
        rx_ready = 1'b1;
        rx_q.delete(); shift_stamps.delete();
        rx_in = 1'b0;
        repeat (4) step();
        rx_in = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", seen); end
        idle(20);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        checks++;
        if (shift_stamps.size() != 0) begin
            errors++; $display("FAIL glitch_shifts: got %0d expected 0", shift_stamps.size());
        end
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL glitch_rx: got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        logic [7:0] d;
        logic       p;
        logic       s;
        int         bad;
        rx_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            exp = model_rx(d, p, s);
            idle($urandom_range(3, 12));
            rx_q.delete(); shift_stamps.delete();
            send_frame(d, p, s);
            idle(4);
            @(negedge clk);
            checks++;
            if (shift_stamps.size() != 11) begin
                errors++; $display("FAIL rand%0d_shifts: got %0d expected 11", n, shift_stamps.size());
            end
            bad = 0;
            for (int i = 1; i < shift_stamps.size(); i++)
                if (shift_stamps[i] - shift_stamps[i-1] != BIT_T) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rand%0d_spacing: got %0d bad gaps expected 0", n, bad); end
            checks++;
            if (rx_q.size() != 1) begin
                errors++; $display("FAIL rand%0d_count: got %0d expected 1", n, rx_q.size());
            end else begin
                checks++;
                if (rx_q[0] !== exp) begin
                    errors++; $display("FAIL rand%0d_entry: got %h expected %h", n, rx_q[0], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ovr_base;
        idle(5);
        rx_ready = 1'b0;
        rx_q.delete();
        ovr_base = ovr_cnt;
        send_frame(8'h11, good_par(8'h11), 1'b1);
        send_frame(8'h22, good_par(8'h22), 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (ovr_cnt - ovr_base != 1) begin
            errors++; $display("FAIL b2b_overrun: got %0d pulses expected 1", ovr_cnt - ovr_base);
        end
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
        checks++;
        if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data: got %h expected 11", rx_data); end
        checks++;
        if ({parity_err, frame_err} !== 2'b00) begin
            errors++; $display("FAIL b2b_flags: got %b expected 00", {parity_err, frame_err});
        end
        step();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL b2b_count: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== {2'b00, 8'h11}) begin
                errors++; $display("FAIL b2b_entry: got %h expected 011", rx_q[0]);
            end
        end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] f;
        logic [9:0]  exp;
        idle(5);
        rx_ready = 1'b0;
        send_frame(8'h33, good_par(8'h33), 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b expected 1", rx_valid); end
        step();
        f = {1'b1, good_par(8'h77), 8'h77, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_in = f[i];
            repeat (BIT_T) step();
        end
        rx_in = f[5];
        repeat (BIT_T / 2) step();
        rst = 1'b1;
        shift_stamps.delete();
        @(negedge clk);
        checks++;
        if ({sipo_shift, sipo_bit, rx_valid, parity_err, frame_err, overrun_err, busy} !== 7'b0) begin
            errors++;
            $display("FAIL rmid_ctrl: got %b expected 0000000",
                     {sipo_shift, sipo_bit, rx_valid, parity_err, frame_err, overrun_err, busy});
        end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", rx_data); end
        step();
        idle(3);
        rst = 1'b0;
        idle(30);
        @(negedge clk);
        checks++;
        if (shift_stamps.size() != 0) begin
            errors++; $display("FAIL rmid_shifts: got %0d expected 0", shift_stamps.size());
        end
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL rmid_idle: got %b expected 00", {rx_valid, busy});
        end
        step();
        rx_ready = 1'b1;
        rx_q.delete();
        exp = model_rx(8'h5A, good_par(8'h5A), 1'b1);
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        idle(4);
        @(negedge clk);
        checks++;
        if (shift_stamps.size() != 11) begin
            errors++; $display("FAIL rmid_after_shifts: got %0d expected 11", shift_stamps.size());
        end
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL rmid_after_count: got %0d expected 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== exp) begin
                errors++; $display("FAIL rmid_after_entry: got %h expected %h", rx_q[0], exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
